// File: rtl/u_pulse_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : u_pulse_monitor
// Description : Measures the number of clock cycles between consecutive U=1
//               samples and queues each interval in a small result FIFO.
//               Optional macro PULSE_MON_DROP_CNT_EN adds a saturating
//               drop_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module u_pulse_monitor #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             U,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_data,
  output logic [15:0]      pulse_count,
  output logic             overflow
`ifdef PULSE_MON_DROP_CNT_EN
  ,
  output logic [7:0]       drop_count
`endif
);

  localparam int                 c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [c_PTR_W:0]   c_PTR_ONE = (c_PTR_W + 1)'(1);

  typedef enum logic [0:0] {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_result_push;

  logic [CNT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W:0]   r_wr_ptr;
  logic [c_PTR_W:0]   r_rd_ptr;
  logic [c_PTR_W-1:0] w_wr_idx;
  logic [c_PTR_W-1:0] w_rd_idx;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_wr_en;
  logic               w_drop;

  logic [15:0]        r_pulse_count;
  logic               r_overflow;

  // ------------------------------------------------------------------------
  // Interval measurement FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_FIRST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_result_push = 1'b0;
    case (r_state)
      WAIT_FIRST: begin
        if (U) begin
          w_state_nxt = MEASURE;
          w_cnt_nxt   = c_CNT_ONE;
        end
      end
      MEASURE: begin
        if (U) begin
          w_result_push = 1'b1;
          w_cnt_nxt     = c_CNT_ONE;
        end else if (r_cnt != c_CNT_MAX) begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = WAIT_FIRST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Result FIFO: pointers carry one extra wrap bit to tell full from empty
  // ------------------------------------------------------------------------
  assign w_wr_idx = r_wr_ptr[c_PTR_W-1:0];
  assign w_rd_idx = r_rd_ptr[c_PTR_W-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]);
  assign w_pop    = !w_empty && out_ready;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_wr_en  = w_result_push && (!w_full || w_pop);
  assign w_drop   = w_result_push && w_full && !w_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[w_wr_idx] <= r_cnt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[w_rd_idx];

  // ------------------------------------------------------------------------
  // Status counters
  // ------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pulse_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (U) begin
        r_pulse_count <= r_pulse_count + 16'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign pulse_count = r_pulse_count;
  assign overflow    = r_overflow;

`ifdef PULSE_MON_DROP_CNT_EN
  logic [7:0] r_drop_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_u_pulse_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_u_pulse_monitor
// Description : Self-checking bench for u_pulse_monitor; the reference model
//               tracks the cycle index of the last high sample and a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_u_pulse_monitor;

  localparam int CNT_W      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int MAXV       = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             U;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_data;
  logic [15:0]      pulse_count;
  logic             overflow;
`ifdef PULSE_MON_DROP_CNT_EN
  logic [7:0]       drop_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int cyc;
  int last_hi;
  int q[$];
  int m_pc;
  bit m_ovf;
  int m_drops;

  u_pulse_monitor #(
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .U           (U),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .pulse_count (pulse_count),
    .overflow    (overflow)
`ifdef PULSE_MON_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    cyc     = 0;
    last_hi = -1;
    q.delete();
    m_pc    = 0;
    m_ovf   = 1'b0;
    m_drops = 0;
  endfunction

  function automatic logic [CNT_W-1:0] exp_data();
    if (q.size() == 0) return '0;
    return CNT_W'(q[0]);
  endfunction

  // Drive one cycle of inputs, let the clock edge occur, advance the model.
  task automatic cycle(input logic u, input logic rdy);
    int val;
    U         = u;
    out_ready = rdy;
    @(posedge clock);
    cyc++;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (u && last_hi >= 0) begin
      val = cyc - last_hi;
      if (val > MAXV) val = MAXV;
      if (q.size() < FIFO_DEPTH) q.push_back(val);
      else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    if (u) begin
      last_hi = cyc;
      m_pc    = (m_pc + 1) % 65536;
    end
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    U         = 1'b0;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    U         = 1'b0;
    out_ready = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %0d expected 0", out_data); end
    checks++;
    if (pulse_count !== 16'd0) begin errors++; $display("FAIL reset_pcount: got %0d expected 0", pulse_count); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
`ifdef PULSE_MON_DROP_CNT_EN
    checks++;
    if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drops: got %0d expected 0", drop_count); end
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_periodic();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b1);
      if (k == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL periodic_first: got valid %0b expected 0", out_valid); end
      end else begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== CNT_W'(4))
          begin errors++; $display("FAIL periodic_data: got valid %0b data %0d expected valid 1 data 4", out_valid, out_data); end
      end
      checks++;
      if (pulse_count !== 16'(k + 1)) begin errors++; $display("FAIL periodic_pcount: got %0d expected %0d", pulse_count, k + 1); end
      for (int j = 0; j < 3; j++) begin
        cycle(1'b0, 1'b1);
        checks++;
        if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL periodic_gap_valid: got %0b expected %0b", out_valid, q.size() > 0); end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== CNT_W'(1))
      begin errors++; $display("FAIL b2b_first: got valid %0b data %0d expected valid 1 data 1", out_valid, out_data); end
    cycle(1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== CNT_W'(1))
      begin errors++; $display("FAIL b2b_second: got valid %0b data %0d expected valid 1 data 1", out_valid, out_data); end
    cycle(1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got valid %0b expected 0", out_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    cycle(1'b1, 1'b1);
    repeat (299) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== CNT_W'(MAXV))
      begin errors++; $display("FAIL saturation: got valid %0b data %0d expected valid 1 data %0d", out_valid, out_data, MAXV); end
  endtask

  task automatic test_overflow();
    do_reset();
    cycle(1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      repeat (i - 1) cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      if (i == 4) begin
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %0b expected 0", overflow); end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", overflow); end
`ifdef PULSE_MON_DROP_CNT_EN
    checks++;
    if (drop_count !== 8'd2) begin errors++; $display("FAIL ovf_drops: got %0d expected 2", drop_count); end
`endif
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== CNT_W'(k))
        begin errors++; $display("FAIL ovf_drain: got valid %0b data %0d expected valid 1 data %0d", out_valid, out_data, k); end
      cycle(1'b0, 1'b1);
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got valid %0b expected 0", out_valid); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    int n;
    do_reset();
    cycle(1'b1, 1'b0);
    repeat (4) begin
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
    end
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf: got %0b expected 0", overflow); end
    n = 0;
    while (out_valid === 1'b1 && n < 10) begin
      cycle(1'b0, 1'b1);
      n++;
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL fullpp_occupancy: got %0d entries expected 4", n); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got valid %0b expected 1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || pulse_count !== 16'd0)
      begin errors++; $display("FAIL areset_immediate: got valid %0b pcount %0d expected 0 0", out_valid, pulse_count); end
    #2;
    reset = 1'b0;
    model_reset();
    cycle(1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || pulse_count !== 16'd1)
      begin errors++; $display("FAIL areset_first: got valid %0b pcount %0d expected 0 1", out_valid, pulse_count); end
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== CNT_W'(2))
      begin errors++; $display("FAIL areset_second: got valid %0b data %0d expected 1 2", out_valid, out_data); end
  endtask

  task automatic test_random();
    logic u;
    logic rdy;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      u   = ($urandom_range(0, 99) < ((i < 400) ? 35 : 2));
      rdy = ($urandom_range(0, 1) == 1);
      cycle(u, rdy);
      checks++;
      if (out_valid !== (q.size() > 0) || out_data !== exp_data())
        begin errors++; $display("FAIL rand_head @%0d: got valid %0b data %0d expected valid %0b data %0d", i, out_valid, out_data, q.size() > 0, exp_data()); end
      checks++;
      if (pulse_count !== 16'(m_pc) || overflow !== m_ovf)
        begin errors++; $display("FAIL rand_status @%0d: got pcount %0d ovf %0b expected %0d %0b", i, pulse_count, overflow, m_pc, m_ovf); end
`ifdef PULSE_MON_DROP_CNT_EN
      checks++;
      if (drop_count !== 8'(m_drops))
        begin errors++; $display("FAIL rand_drops @%0d: got %0d expected %0d", i, drop_count, m_drops); end
`endif
    end
  endtask

  initial begin
    reset     = 1'b1;
    U         = 1'b0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_periodic();
    test_back_to_back();
    test_saturation();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/u_pulse_monitor.md
U_PULSE_MONITOR -- requirements
Module: u_pulse_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the interval counter and of out_data.
REQ-002 Parameter FIFO_DEPTH, default 4: number of interval result entries; SHALL be a power of two and at least 2.
REQ-003 Port clock, input, 1: the single clock; all state updates on its posedge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port U, input, 1: detector output pulse, sampled on each posedge clock.
REQ-006 Port out_valid, output, 1: the head result entry is valid.
REQ-007 Port out_ready, input, 1: the consumer accepts the head entry.
REQ-008 Port out_data, output, CNT_W: the head interval value, in clock cycles.
REQ-009 Port pulse_count, output, 16: running count of sampled U=1 cycles.
REQ-010 Port overflow, output, 1: sticky flag; at least one result was dropped.
REQ-011 Port drop_count, output, 8: present only when PULSE_MON_DROP_CNT_EN is defined.

Function
REQ-012 The FSM SHALL have two states, WAIT_FIRST and MEASURE.
REQ-013 In WAIT_FIRST, a cycle with U=1 SHALL move the FSM to MEASURE and load the interval counter with 1; no result is produced.
REQ-014 In MEASURE, a cycle with U=0 SHALL increment the interval counter, saturating at 2^CNT_W-1.
REQ-015 In MEASURE, a cycle with U=1 SHALL push the current counter value as a result and reload the counter with 1.
REQ-016 Each result value SHALL equal the number of cycles between consecutive U=1 samples; back-to-back highs give 1; a saturated value means "at least 2^CNT_W-1".
REQ-017 A pushed result SHALL appear on out_valid/out_data on the cycle after the U=1 sample when the FIFO was empty (latency 1).
REQ-018 out_valid SHALL be high exactly while the FIFO is non-empty; out_data SHALL hold the oldest entry.
REQ-019 An entry SHALL be popped on a posedge where out_valid=1 and out_ready=1.
REQ-020 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 A push while the FIFO is full with no pop SHALL drop the result and set overflow; the FIFO contents are unchanged.
REQ-022 A simultaneous push and pop when the FIFO is full SHALL accept both; nothing is dropped and occupancy is unchanged.
REQ-023 A simultaneous push and pop when the FIFO is empty SHALL be impossible, because out_valid=0; the push alone occurs.
REQ-024 pulse_count SHALL increment on every U=1 sample in either state, wrapping from 65535 to 0.
REQ-025 overflow SHALL remain set until reset.

Reset
REQ-026 While reset=1: FSM=WAIT_FIRST, interval counter=0, FIFO empty, out_valid=0, out_data=0, pulse_count=0, overflow=0, drop_count=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight interval and FIFO state immediately, without waiting for a clock edge.
REQ-028 The first posedge after reset deasserts SHALL be treated as a normal WAIT_FIRST cycle.

Configuration
REQ-029 Macro PULSE_MON_DROP_CNT_EN defined: the drop_count port exists and increments on each dropped result, saturating at 255.
REQ-030 Macro PULSE_MON_DROP_CNT_EN undefined: the drop_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-031 Reset, then U high one cycle in every 4 with out_ready=1 -> first pulse produces nothing; every later pulse yields out_data=4; pulse_count tracks the pulse count.
REQ-032 U high for 3 consecutive cycles after WAIT_FIRST -> results 1, 1 delivered in order.
REQ-033 CNT_W=8, U pulses 300 cycles apart -> out_data=255 (saturated).
REQ-034 out_ready=0, 6 intervals generated with FIFO_DEPTH=4 -> 4 entries held; overflow=1; drop_count=2 when the macro is defined; draining returns the first 4 values in order.
REQ-035 FIFO full, a push coincides with out_ready=1 -> no drop; overflow stays 0; occupancy stays 4.
REQ-036 Reset asserted between clock edges while the FIFO holds entries -> out_valid=0 immediately; the next pulse behaves as the first pulse.
